fetch_pc_unit: RTL and testbench

//  F-stage consumer of the D-stage next-PC result: owns the PC register, fetches from

---
 rtl/fetch_pc_unit_pkg.sv | 18 +
 rtl/fetch_pc_unit_redirect_latch.sv | 46 ++++
 rtl/fetch_pc_unit.sv | 105 ++++++++++
 tb/tb_fetch_pc_unit.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/fetch_pc_unit_pkg.sv
// Shared constants, FSM state type and fetch-address legality check for the F-stage PC unit.
package fetch_pc_unit_pkg;

  localparam logic [31:0] PC_RESET = 32'h0000_3000;
  localparam logic [31:0] IM_LO    = 32'h0000_3000;
  localparam logic [31:0] IM_HI    = 32'h0000_6FFC;

  typedef enum logic {
    FS_FETCH = 1'b0,
    FS_HOLD  = 1'b1
  } fstate_t;

  // Word-aligned and inside the instruction memory window; anything else raises AdEL.
  function automatic logic pc_legal(input logic [31:0] pc);
    return (pc[1:0] == 2'b00) && (pc >= IM_LO) && (pc <= IM_HI);
  endfunction

endpackage

// File: rtl/fetch_pc_unit_redirect_latch.sv
// Holds a taken redirect until the delay-slot instruction is consumed; a redirect seen in
// the consume cycle itself is bypassed straight to next_pc.
module fetch_pc_unit_redirect_latch
  import fetch_pc_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        clear,
  input  logic [31:0] pc_plus4,
  output logic [31:0] next_pc
);

  logic        pending_reg;
  logic        pending_next;
  logic [31:0] pending_pc_reg;
  logic [31:0] pending_pc_next;

  always_comb begin
    pending_next    = pending_reg;
    pending_pc_next = pending_pc_reg;
    if (redirect_valid) begin
      pending_next    = 1'b1;
      pending_pc_next = redirect_pc;
    end
    // Consumption wins: a redirect present now is used via the bypass below.
    if (clear) begin
      pending_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pending_reg    <= 1'b0;
      pending_pc_reg <= 32'h0;
    end else begin
      pending_reg    <= pending_next;
      pending_pc_reg <= pending_pc_next;
    end
  end

  assign next_pc = redirect_valid ? redirect_pc :
                   pending_reg    ? pending_pc_reg : pc_plus4;

endmodule

// File: rtl/fetch_pc_unit.sv
// F stage: PC register, FETCH/HOLD handshake FSM with instruction memory, and the F/D
// output registers. The delay-slot instruction is always delivered before a redirect applies.
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_ack,
  input  logic [31:0] im_rdata,
  output logic        valid_F,
  output logic [31:0] pc_F,
  output logic [31:0] instr_F,
  output logic        adel_F
);

  fstate_t     state_reg;
  fstate_t     state_next;
  logic [31:0] pc_reg;
  logic [31:0] pc_next;
  logic [31:0] pc_f_reg;
  logic [31:0] pc_f_next;
  logic [31:0] instr_f_reg;
  logic [31:0] instr_f_next;
  logic        adel_f_reg;
  logic        adel_f_next;
  logic        consume;
  logic        legal;
  logic [31:0] next_pc;

  assign legal   = pc_legal(pc_reg);
  assign consume = (state_reg == FS_HOLD) && !stall;

  fetch_pc_unit_redirect_latch u_redirect_latch (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .clear          (consume),
    .pc_plus4       (pc_reg + 32'd4),
    .next_pc        (next_pc)
  );

  always_comb begin
    state_next   = state_reg;
    pc_next      = pc_reg;
    pc_f_next    = pc_f_reg;
    instr_f_next = instr_f_reg;
    adel_f_next  = adel_f_reg;
    im_req       = 1'b0;
    case (state_reg)
      FS_FETCH: begin
        if (legal) begin
          im_req = 1'b1;
          if (im_ack) begin
            pc_f_next    = pc_reg;
            instr_f_next = im_rdata;
            adel_f_next  = 1'b0;
            state_next   = FS_HOLD;
          end
        end else begin
          // Illegal address never reaches IM; deliver an AdEL-tagged bubble instead.
          pc_f_next    = pc_reg;
          instr_f_next = 32'h0;
          adel_f_next  = 1'b1;
          state_next   = FS_HOLD;
        end
      end
      FS_HOLD: begin
        if (consume) begin
          pc_next    = next_pc;
          state_next = FS_FETCH;
        end
      end
      default: state_next = FS_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg   <= FS_FETCH;
      pc_reg      <= PC_RESET;
      pc_f_reg    <= 32'h0;
      instr_f_reg <= 32'h0;
      adel_f_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      pc_f_reg    <= pc_f_next;
      instr_f_reg <= instr_f_next;
      adel_f_reg  <= adel_f_next;
    end
  end

  assign im_addr = pc_reg;
  assign valid_F = (state_reg == FS_HOLD);
  assign pc_F    = pc_f_reg;
  assign instr_F = instr_f_reg;
  assign adel_F  = adel_f_reg;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: sequential fetch, delayed ack, delay-slot redirect,
// stall with held redirect, AdEL cases and mid-fetch reset.
module tb_fetch_pc_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ack;
  logic [31:0] im_rdata;
  logic        valid_F;
  logic [31:0] pc_F;
  logic [31:0] instr_F;
  logic        adel_F;

  int n_checks;
  int n_fails;

  fetch_pc_unit dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .im_req         (im_req),
    .im_addr        (im_addr),
    .im_ack         (im_ack),
    .im_rdata       (im_rdata),
    .valid_F        (valid_F),
    .pc_F           (pc_F),
    .instr_F        (instr_F),
    .adel_F         (adel_F)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory content: address tagged with a fixed pattern.
  assign im_rdata = im_addr ^ 32'hDEAD_0000;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_fetch(input string tag, input logic [31:0] addr, input logic req);
    check({tag, ".valid"}, {31'h0, valid_F}, 32'h0);
    check({tag, ".addr"}, im_addr, addr);
    check({tag, ".req"}, {31'h0, im_req}, {31'h0, req});
  endtask

  task automatic expect_hold(input string tag, input logic [31:0] pc,
                             input logic [31:0] instr, input logic adel);
    check({tag, ".valid"}, {31'h0, valid_F}, 32'h1);
    check({tag, ".pc_F"}, pc_F, pc);
    check({tag, ".instr_F"}, instr_F, instr);
    check({tag, ".adel_F"}, {31'h0, adel_F}, {31'h0, adel});
    check({tag, ".req"}, {31'h0, im_req}, 32'h0);
  endtask

  initial begin
    n_checks       = 0;
    n_fails        = 0;
    reset          = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    im_ack         = 1'b1;
    tick();
    tick();
    check("rst.valid", {31'h0, valid_F}, 32'h0);
    check("rst.pc_F", pc_F, 32'h0);
    check("rst.instr_F", instr_F, 32'h0);
    check("rst.adel_F", {31'h0, adel_F}, 32'h0);
    check("rst.addr", im_addr, 32'h0000_3000);
    reset = 1'b1;

    // 1: back-to-back fetch with same-cycle ack
    expect_fetch("t1.f0", 32'h3000, 1'b1);
    tick(); expect_hold("t1.h0", 32'h3000, 32'hDEAD_3000, 1'b0);
    tick(); expect_fetch("t1.f1", 32'h3004, 1'b1);
    tick(); expect_hold("t1.h1", 32'h3004, 32'hDEAD_3004, 1'b0);
    tick(); expect_fetch("t1.f2", 32'h3008, 1'b1);

    // 2: ack delayed three cycles, request held at same address
    im_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); expect_fetch("t2.wait", 32'h3008, 1'b1);
    end
    im_ack = 1'b1;
    tick(); expect_hold("t2.h", 32'h3008, 32'hDEAD_3008, 1'b0);
    tick(); expect_fetch("t2.f", 32'h300C, 1'b1);

    // 3: redirect pulse while 0x300C is in FETCH; delay slot still delivered
    redirect_valid = 1'b1;
    redirect_pc    = 32'h3100;
    tick(); redirect_valid = 1'b0;
    expect_hold("t3.slot", 32'h300C, 32'hDEAD_300C, 1'b0);
    tick(); expect_fetch("t3.tgt", 32'h3100, 1'b1);
    tick(); expect_hold("t3.h", 32'h3100, 32'hDEAD_3100, 1'b0);
    tick(); expect_fetch("t3.seq", 32'h3104, 1'b1);
    tick(); expect_hold("t4.h", 32'h3104, 32'hDEAD_3104, 1'b0);

    // 4: stall in HOLD with redirect held high; consume cycle bypasses the redirect
    stall          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h3200;
    for (int i = 0; i < 5; i++) begin
      tick(); expect_hold("t4.stall", 32'h3104, 32'hDEAD_3104, 1'b0);
    end
    stall = 1'b0;
    tick(); redirect_valid = 1'b0;
    expect_fetch("t4.tgt", 32'h3200, 1'b1);
    tick(); expect_hold("t4.h2", 32'h3200, 32'hDEAD_3200, 1'b0);
    tick(); expect_fetch("t4.seq", 32'h3204, 1'b1);

    // 5: misaligned and out-of-range targets raise AdEL without an IM request
    redirect_valid = 1'b1;
    redirect_pc    = 32'h3102;
    tick(); redirect_valid = 1'b0;
    expect_hold("t5.slot", 32'h3204, 32'hDEAD_3204, 1'b0);
    tick(); expect_fetch("t5.mis", 32'h3102, 1'b0);
    tick(); expect_hold("t5.mis", 32'h3102, 32'h0, 1'b1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h7000;
    tick(); redirect_valid = 1'b0;
    expect_fetch("t5.oor", 32'h7000, 1'b0);
    tick(); expect_hold("t5.oor", 32'h7000, 32'h0, 1'b1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h6FFC;
    tick(); redirect_valid = 1'b0;
    expect_fetch("t5.top", 32'h6FFC, 1'b1);
    tick(); expect_hold("t5.top", 32'h6FFC, 32'hDEAD_6FFC, 1'b0);

    // 6: reset during an un-acked fetch with a redirect pending
    redirect_valid = 1'b1;
    redirect_pc    = 32'h3300;
    tick(); redirect_valid = 1'b0;
    im_ack = 1'b0;
    expect_fetch("t6.f", 32'h3300, 1'b1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h3400;
    tick(); redirect_valid = 1'b0;
    reset = 1'b0;
    tick();
    check("t6.rst.addr", im_addr, 32'h3000);
    check("t6.rst.valid", {31'h0, valid_F}, 32'h0);
    check("t6.rst.pc_F", pc_F, 32'h0);
    reset  = 1'b1;
    im_ack = 1'b1;
    tick(); expect_hold("t6.h", 32'h3000, 32'hDEAD_3000, 1'b0);
    tick(); expect_fetch("t6.seq", 32'h3004, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
